// File: rtl/cs_decode_seq.sv
// cs_decode_seq: registered chip-select decoder for the 68000 front-side bus.
// The address is decoded once at the start of each bus cycle and the selects are
// held until the cycle ends. The block also runs the boot-overlay FSM, a wait-state
// counter that drives Ready, and a timeout that raises BErr on unmapped cycles.
module cs_decode_seq #(
  parameter int AW       = 24,
  parameter int RAM_WS   = 0,
  parameter int ROM_WS   = 2,
  parameter int IO_WS    = 4,
  parameter int TO_CYC   = 64,
  parameter int VIDWR_EN = 1
) (
  input  logic          i_clk,
  input  logic          i_nres,
  input  logic [AW-9:0] i_a,
  input  logic          i_nwe,
  input  logic          i_bact,
  input  logic          i_ovlset,
  output logic          o_ramcs,
  output logic          o_romcs,
  output logic          o_iocs,
  output logic          o_scsics,
  output logic          o_iacs,
  output logic          o_iopwcs,
  output logic          o_sndramcswr,
  output logic          o_ready,
  output logic          o_berr,
  output logic          o_overlay
);

  typedef enum logic [1:0] {OVL_ON, OVL_ARM, OVL_OFF, OVL_PEND} ovl_state_t;

  ovl_state_t  r_state;
  logic        r_overlay;
  logic        r_bact_q;
  logic        r_mapped;
  logic [7:0]  r_cnt;
  logic        r_ramcs, r_romcs, r_iocs, r_scsics, r_iacs, r_iopwcs, r_snd;
  logic        r_ready, r_berr;

  // Full byte address with the low byte zeroed, so bit numbers match the CPU map.
  logic [AW-1:0] w_addr;
  logic [3:0]    w_hi, w_nib;
  logic          w_ovl, w_inrange, w_start;
  logic          w_ram, w_rom, w_io, w_scsi, w_iacs, w_vid64k, w_vidwr, w_snd, w_iopw;
  logic          w_mapped;
  logic [7:0]    w_load, w_cnt_dec;

  assign w_addr    = {i_a, 8'h00};
  assign w_hi      = w_addr[23:20];
  assign w_nib     = w_addr[15:12];
  assign w_ovl     = r_overlay;
  assign w_inrange = ((w_addr >> 24) == '0);
  assign w_start   = i_bact & ~r_bact_q;

  assign w_ram    = (~w_ovl & (w_addr[23:22] == 2'b00)) | (w_ovl & (w_addr[23:21] == 3'b011));
  assign w_rom    = (w_hi == 4'h4) | ((w_hi == 4'h0) & w_ovl);
  assign w_scsi   = (w_hi == 4'h5);
  assign w_iacs   = (w_addr[23:8] == 16'hFFFF);
  assign w_vid64k = (VIDWR_EN != 0) & w_ram & (w_addr[21:16] == 6'h3F) & ~i_nwe;
  assign w_vidwr  = w_vid64k & (w_nib inside {[4'h2:4'h7], [4'hA:4'hF]});
  assign w_snd    = w_vid64k & (w_addr[15:8] inside {8'hFD, 8'hFE, 8'hFF, 8'hA1, 8'hA2, 8'hA3});
  assign w_io     = (w_hi == 4'h5) | (w_hi >= 4'h8) | w_vidwr;
  assign w_iopw   = (w_addr[23:22] == 2'b00) & ~w_ovl & ~i_nwe;
  assign w_mapped = w_inrange & (w_ram | w_rom | w_io | w_iacs);

  // A video write selects both RAM and IO; the slower IO timing must win so the
  // IO side has time to latch the data. ROM and RAM never overlap with each other.
  assign w_load    = !w_mapped ? 8'(TO_CYC) :
                     w_io      ? 8'(IO_WS)  :
                     w_rom     ? 8'(ROM_WS) : 8'(RAM_WS);
  assign w_cnt_dec = (r_cnt == 8'd0) ? 8'd0 : r_cnt - 8'd1;

  // Latch selects at cycle start, count wait states / timeout, clear on BACT low.
  always_ff @(posedge i_clk or negedge i_nres) begin
    if (!i_nres) begin
      r_bact_q <= 1'b0;
      r_mapped <= 1'b0;
      r_cnt    <= 8'd0;
      r_ramcs  <= 1'b0; r_romcs  <= 1'b0; r_iocs <= 1'b0; r_scsics <= 1'b0;
      r_iacs   <= 1'b0; r_iopwcs <= 1'b0; r_snd  <= 1'b0;
      r_ready  <= 1'b0;
      r_berr   <= 1'b0;
    end else begin
      r_bact_q <= i_bact;
      if (!i_bact) begin
        r_mapped <= 1'b0;
        r_cnt    <= 8'd0;
        r_ramcs  <= 1'b0; r_romcs  <= 1'b0; r_iocs <= 1'b0; r_scsics <= 1'b0;
        r_iacs   <= 1'b0; r_iopwcs <= 1'b0; r_snd  <= 1'b0;
        r_ready  <= 1'b0;
        r_berr   <= 1'b0;
      end else if (w_start) begin
        r_mapped <= w_mapped;
        r_cnt    <= w_load;
        r_ramcs  <= w_mapped & w_ram;
        r_romcs  <= w_mapped & w_rom;
        r_iocs   <= w_mapped & w_io;
        r_scsics <= w_mapped & w_scsi;
        r_iacs   <= w_mapped & w_iacs;
        r_iopwcs <= w_mapped & w_iopw;
        r_snd    <= w_mapped & w_snd;
        r_ready  <= w_mapped & (w_load == 8'd0);
        r_berr   <= ~w_mapped & (w_load == 8'd0);
      end else begin
        r_cnt   <= w_cnt_dec;
        r_ready <= r_mapped & (w_cnt_dec == 8'd0);
        r_berr  <= ~r_mapped & (w_cnt_dec == 8'd0);
      end
    end
  end

  // Boot overlay: first ROM-window access arms turn-off; OvlSet re-enables at idle.
  always_ff @(posedge i_clk or negedge i_nres) begin
    if (!i_nres) begin
      r_state   <= OVL_ON;
      r_overlay <= 1'b1;
    end else begin
      case (r_state)
        OVL_ON:   if (w_start && w_hi == 4'h4) r_state <= OVL_ARM;
        OVL_ARM:  if (!i_bact) begin r_state <= OVL_OFF;  r_overlay <= 1'b0; end
        OVL_OFF:  if (i_ovlset) begin r_state <= OVL_PEND; r_overlay <= 1'b1; end
        OVL_PEND: if (!i_bact) r_state <= OVL_ON;
        default:  begin r_state <= OVL_ON; r_overlay <= 1'b1; end
      endcase
    end
  end

  assign o_ramcs      = r_ramcs;
  assign o_romcs      = r_romcs;
  assign o_iocs       = r_iocs;
  assign o_scsics     = r_scsics;
  assign o_iacs       = r_iacs;
  assign o_iopwcs     = r_iopwcs;
  assign o_sndramcswr = r_snd;
  assign o_ready      = r_ready;
  assign o_berr       = r_berr;
  assign o_overlay    = r_overlay;

endmodule

// File: tb/tb_cs_decode_seq.sv
// Directed bench for cs_decode_seq (AW=26, default wait states, TO_CYC=64).
module tb_cs_decode_seq;
  logic        clk = 1'b0;
  logic        nres, nwe, bact, ovlset;
  logic [17:0] a;
  logic ramcs, romcs, iocs, scsics, iacs, iopwcs, snd, ready, berr, overlay;
  int total = 0;
  int bad   = 0;

  // Select vector order: RAM ROM IO SCSI IACS IOPW SND
  wire [6:0] sel = {ramcs, romcs, iocs, scsics, iacs, iopwcs, snd};

  cs_decode_seq #(.AW(26)) dut (
    .i_clk(clk), .i_nres(nres), .i_a(a), .i_nwe(nwe), .i_bact(bact), .i_ovlset(ovlset),
    .o_ramcs(ramcs), .o_romcs(romcs), .o_iocs(iocs), .o_scsics(scsics), .o_iacs(iacs),
    .o_iopwcs(iopwcs), .o_sndramcswr(snd), .o_ready(ready), .o_berr(berr), .o_overlay(overlay)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic start_cyc(input logic [25:0] ad, input logic w);
    a = ad[25:8]; nwe = w; bact = 1'b1; step();
  endtask

  task automatic end_cyc();
    bact = 1'b0; nwe = 1'b1; step();
  endtask

  task automatic test_reset();
    nres = 1'b0; bact = 1'b0; nwe = 1'b1; ovlset = 1'b0; a = '0;
    #12;
    total++; if (sel !== 7'b0 || ready !== 1'b0 || berr !== 1'b0) begin bad++;
      $display("FAIL reset_out: sel=%b ready=%b berr=%b want 0", sel, ready, berr); end
    total++; if (overlay !== 1'b1) begin bad++;
      $display("FAIL reset_ovl: overlay=%b want 1", overlay); end
    @(negedge clk); nres = 1'b1; step();
  endtask

  task automatic test_rom_boot();
    start_cyc(26'h000100, 1'b1);
    total++; if (sel !== 7'b0100000 || ready !== 1'b0) begin bad++;
      $display("FAIL boot_sel: sel=%b ready=%b want 0100000/0", sel, ready); end
    step();
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL boot_rdy2: ready=%b want 0", ready); end
    step();
    total++; if (ready !== 1'b1 || sel !== 7'b0100000) begin bad++;
      $display("FAIL boot_rdy3: ready=%b sel=%b want 1/0100000", ready, sel); end
    end_cyc();
    total++; if (sel !== 7'b0 || ready !== 1'b0 || overlay !== 1'b1) begin bad++;
      $display("FAIL boot_end: sel=%b ready=%b ovl=%b want 0/0/1", sel, ready, overlay); end
  endtask

  task automatic test_mid_change();
    start_cyc(26'h600000, 1'b1);
    total++; if (sel !== 7'b1000000 || ready !== 1'b1) begin bad++;
      $display("FAIL mid_start: sel=%b ready=%b want 1000000/1", sel, ready); end
    a = 18'h05000;
    step(); step();
    total++; if (sel !== 7'b1000000) begin bad++;
      $display("FAIL mid_hold: sel=%b want 1000000", sel); end
    end_cyc();
    total++; if (sel !== 7'b0) begin bad++; $display("FAIL mid_end: sel=%b want 0", sel); end
  endtask

  task automatic test_overlay_off();
    start_cyc(26'h400000, 1'b1);
    total++; if (sel !== 7'b0100000 || overlay !== 1'b1) begin bad++;
      $display("FAIL ovl_rom: sel=%b ovl=%b want 0100000/1", sel, overlay); end
    step(); step();
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL ovl_rdy: ready=%b want 1", ready); end
    end_cyc();
    total++; if (overlay !== 1'b0 || sel !== 7'b0) begin bad++;
      $display("FAIL ovl_off: ovl=%b sel=%b want 0/0", overlay, sel); end
    start_cyc(26'h000100, 1'b1);
    total++; if (sel !== 7'b1000000 || ready !== 1'b1) begin bad++;
      $display("FAIL ovl_ram: sel=%b ready=%b want 1000000/1", sel, ready); end
    end_cyc();
  endtask

  task automatic test_vidwr();
    start_cyc(26'h3FFD10, 1'b0);
    total++; if (sel !== 7'b1010011 || ready !== 1'b0) begin bad++;
      $display("FAIL vid_sel: sel=%b ready=%b want 1010011/0", sel, ready); end
    step(); step(); step();
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL vid_rdy4: ready=%b want 0", ready); end
    step();
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL vid_rdy5: ready=%b want 1", ready); end
    end_cyc();
    start_cyc(26'h3F1000, 1'b0);
    total++; if (sel !== 7'b1000010 || ready !== 1'b1) begin bad++;
      $display("FAIL vid_nib1: sel=%b ready=%b want 1000010/1", sel, ready); end
    end_cyc();
    start_cyc(26'h3FA100, 1'b0);
    total++; if (sel !== 7'b1010011 || ready !== 1'b0) begin bad++;
      $display("FAIL vid_snda1: sel=%b ready=%b want 1010011/0", sel, ready); end
    end_cyc();
    start_cyc(26'h3FFD10, 1'b1);
    total++; if (sel !== 7'b1000000 || ready !== 1'b1) begin bad++;
      $display("FAIL vid_read: sel=%b ready=%b want 1000000/1", sel, ready); end
    end_cyc();
  endtask

  task automatic test_abort();
    start_cyc(26'h400000, 1'b1);
    total++; if (sel !== 7'b0100000) begin bad++; $display("FAIL abort_sel: sel=%b want 0100000", sel); end
    step();
    bact = 1'b0; step();
    total++; if (ready !== 1'b0 || sel !== 7'b0 || overlay !== 1'b0) begin bad++;
      $display("FAIL abort_end: ready=%b sel=%b ovl=%b want 0/0/0", ready, sel, overlay); end
  endtask

  task automatic test_unmapped();
    logic early;
    start_cyc(26'h1000000, 1'b1);
    total++; if (sel !== 7'b0 || ready !== 1'b0 || berr !== 1'b0) begin bad++;
      $display("FAIL um_start: sel=%b ready=%b berr=%b want 0", sel, ready, berr); end
    early = 1'b0;
    for (int i = 1; i < 64; i++) begin
      step();
      if (berr !== 1'b0 || ready !== 1'b0) early = 1'b1;
    end
    total++; if (early) begin bad++; $display("FAIL um_early: berr/ready before 64, got 1 want 0"); end
    step();
    total++; if (berr !== 1'b1 || ready !== 1'b0) begin bad++;
      $display("FAIL um_berr: berr=%b ready=%b want 1/0", berr, ready); end
    step();
    total++; if (berr !== 1'b1) begin bad++; $display("FAIL um_hold: berr=%b want 1", berr); end
    end_cyc();
    total++; if (berr !== 1'b0) begin bad++; $display("FAIL um_clr: berr=%b want 0", berr); end
    start_cyc(26'h700000, 1'b1);
    total++; if (sel !== 7'b0 || ready !== 1'b0) begin bad++;
      $display("FAIL um_700000: sel=%b ready=%b want 0/0", sel, ready); end
    end_cyc();
  endtask

  task automatic test_ovlset();
    start_cyc(26'h000100, 1'b1);
    total++; if (sel !== 7'b1000000 || overlay !== 1'b0) begin bad++;
      $display("FAIL set_ram: sel=%b ovl=%b want 1000000/0", sel, overlay); end
    ovlset = 1'b1; step(); ovlset = 1'b0;
    total++; if (overlay !== 1'b1 || sel !== 7'b1000000) begin bad++;
      $display("FAIL set_pend: ovl=%b sel=%b want 1/1000000", overlay, sel); end
    end_cyc();
    total++; if (overlay !== 1'b1) begin bad++; $display("FAIL set_on: ovl=%b want 1", overlay); end
    start_cyc(26'h000100, 1'b1);
    step(); step();
    total++; if (sel !== 7'b0100000 || ready !== 1'b1) begin bad++;
      $display("FAIL set_rom: sel=%b ready=%b want 0100000/1", sel, ready); end
    #2; nres = 1'b0; #1;
    total++; if (sel !== 7'b0 || ready !== 1'b0 || berr !== 1'b0 || overlay !== 1'b1) begin bad++;
      $display("FAIL rst_mid: sel=%b ready=%b berr=%b ovl=%b want 0/0/0/1", sel, ready, berr, overlay); end
    @(negedge clk); nres = 1'b1; step();
    total++; if (sel !== 7'b0100000 || ready !== 1'b0) begin bad++;
      $display("FAIL rst_fresh: sel=%b ready=%b want 0100000/0", sel, ready); end
    end_cyc();
  endtask

  task automatic test_ovlset_rom();
    start_cyc(26'h400000, 1'b1);
    end_cyc();
    total++; if (overlay !== 1'b0) begin bad++; $display("FAIL sr_off: ovl=%b want 0", overlay); end
    ovlset = 1'b1;
    start_cyc(26'h400000, 1'b1);
    ovlset = 1'b0;
    total++; if (overlay !== 1'b1 || sel !== 7'b0100000) begin bad++;
      $display("FAIL sr_same: ovl=%b sel=%b want 1/0100000", overlay, sel); end
    end_cyc();
    total++; if (overlay !== 1'b1) begin bad++; $display("FAIL sr_noarm: ovl=%b want 1", overlay); end
    start_cyc(26'h000100, 1'b1);
    total++; if (sel !== 7'b0100000) begin bad++; $display("FAIL sr_rom0: sel=%b want 0100000", sel); end
    end_cyc();
  endtask

  initial begin
    test_reset();
    test_rom_boot();
    test_mid_change();
    test_overlay_off();
    test_vidwr();
    test_abort();
    test_unmapped();
    test_ovlset();
    test_ovlset_rom();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
